// File: rtl/axis_uart_tx_cfg_pkg.sv
// Shared definitions for the configurable AXIS-to-UART transmitter.
package axis_uart_tx_cfg_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } tx_state_e;

endpackage

// File: rtl/axis_uart_tx_cfg_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty/level flags.
module axis_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    if (wr_en_i && !rd_en_i) begin
      level_d = level_q + 1'b1;
    end else if (!wr_en_i && rd_en_i) begin
      level_d = level_q - 1'b1;
    end
  end

  // Storage array, no reset needed since flags gate every read.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/axis_uart_tx_cfg.sv
// AXI-Stream to UART transmitter with configurable framing, runtime baud
// divisor and optional idle gap after packet-terminating frames.
module axis_uart_tx_cfg
  import axis_uart_tx_cfg_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned IDLE_GAP  = 0,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_BITS-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic [DIV_W-1:0]       baud_div,
  output logic                   uart_tx,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   pkt_done,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned IW = $clog2(DATA_BITS + 1);
  localparam int unsigned GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam int unsigned CW = (IW > GW) ? IW : GW;

  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic [CW-1:0] LAST_GAP  = (IDLE_GAP > 0) ? CW'(IDLE_GAP - 1) : '0;

  logic                 fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [DATA_BITS:0]   fifo_rdata;

  tx_state_e            state_q;
  logic [DIV_W-1:0]     cnt_q, div_q;
  logic [CW-1:0]        idx_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q, last_q;
  logic                 uart_tx_q, tx_done_q, pkt_done_q;

  logic                 bit_end, gap_after, frame_end;
  logic                 line_d, done_d, pkt_d;

  assign s_axis_tready = !fifo_full && !rst;
  assign fifo_wr       = s_axis_tvalid && s_axis_tready;

  axis_sync_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i ({s_axis_tlast, s_axis_tdata}),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  // Bit-boundary detection, frame-end pop and line/pulse next values.
  // The line is registered one cycle behind the FSM state so the pop cycle
  // in IDLE stays high; tx_done/pkt_done share that delay to stay aligned.
  always_comb begin
    bit_end   = (cnt_q == '0);
    gap_after = last_q && (IDLE_GAP != 0);
    frame_end = bit_end &&
                (((state_q == S_STOP) && (idx_q == LAST_STOP) && !gap_after) ||
                 ((state_q == S_GAP)  && (idx_q == LAST_GAP)));
    fifo_rd   = !fifo_empty && ((state_q == S_IDLE) || frame_end);
    done_d    = (state_q == S_STOP) && (idx_q == LAST_STOP) && bit_end;
    pkt_d     = (IDLE_GAP == 0) ? (done_d && last_q)
                                : ((state_q == S_GAP) && (idx_q == LAST_GAP) && bit_end);
    unique case (state_q)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = sh_q[0];
      S_PARITY: line_d = par_q;
      default:  line_d = 1'b1;
    endcase
  end

  // Frame sequencer: loads a beat on pop, then walks start/data/parity/stop/gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      last_q     <= 1'b0;
      uart_tx_q  <= 1'b1;
      tx_done_q  <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      uart_tx_q  <= line_d;
      tx_done_q  <= done_d;
      pkt_done_q <= pkt_d;
      if (fifo_rd) begin
        state_q <= S_START;
        sh_q    <= fifo_rdata[DATA_BITS-1:0];
        last_q  <= fifo_rdata[DATA_BITS];
        par_q   <= (PARITY == PARITY_ODD) ? ~^fifo_rdata[DATA_BITS-1:0]
                                          :  ^fifo_rdata[DATA_BITS-1:0];
        div_q   <= baud_div;
        cnt_q   <= baud_div;
        idx_q   <= '0;
      end else if (state_q != S_IDLE) begin
        if (!bit_end) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          cnt_q <= div_q;
          unique case (state_q)
            S_START: begin
              state_q <= S_DATA;
              idx_q   <= '0;
            end
            S_DATA: begin
              sh_q <= sh_q >> 1;
              if (idx_q == LAST_DATA) begin
                idx_q   <= '0;
                state_q <= (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
            S_PARITY: begin
              state_q <= S_STOP;
              idx_q   <= '0;
            end
            S_STOP: begin
              if (idx_q == LAST_STOP) begin
                idx_q   <= '0;
                state_q <= gap_after ? S_GAP : S_IDLE;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
            S_GAP: begin
              if (idx_q == LAST_GAP) begin
                idx_q   <= '0;
                state_q <= S_IDLE;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign uart_tx  = uart_tx_q;
  assign tx_done  = tx_done_q;
  assign pkt_done = pkt_done_q;
  assign tx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_axis_uart_tx_cfg.sv
// Bench for axis_uart_tx_cfg: four configurations (8N1, 8E1, 8O2, 8N1+gap2)
// checked sample-by-sample against a behavioural frame model.
module tb_axis_uart_tx_cfg;

  localparam int PAR  [4] = '{0, 1, 2, 0};
  localparam int STP  [4] = '{1, 1, 2, 1};
  localparam int GAPB [4] = '{0, 0, 0, 2};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [7:0]  tdata  [4];
  logic        tvalid [4];
  logic        tlast  [4];
  logic        tready [4];
  logic        txl    [4];
  logic        busy   [4];
  logic        done   [4];
  logic        pkt    [4];
  logic [3:0]  level  [4];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic mon_en = 1'b0;
  int   max_level;
  bit   saw_full;
  int   pkt_cnt3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Occupancy / back-pressure / pkt_done observers, cleared while disabled.
  always @(negedge clk) begin
    if (!mon_en) begin
      max_level <= 0;
      saw_full  <= 1'b0;
      pkt_cnt3  <= 0;
    end else begin
      if (int'(level[0]) > max_level) max_level <= int'(level[0]);
      if (!tready[0]) saw_full <= 1'b1;
      if (pkt[3]) pkt_cnt3 <= pkt_cnt3 + 1;
    end
  end

  axis_uart_tx_cfg u_8n1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]),
    .s_axis_tready(tready[0]), .s_axis_tlast(tlast[0]), .baud_div(baud_div),
    .uart_tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]), .pkt_done(pkt[0]),
    .fifo_level(level[0]));

  axis_uart_tx_cfg #(.PARITY(1)) u_8e1 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]),
    .s_axis_tready(tready[1]), .s_axis_tlast(tlast[1]), .baud_div(baud_div),
    .uart_tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]), .pkt_done(pkt[1]),
    .fifo_level(level[1]));

  axis_uart_tx_cfg #(.PARITY(2), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[2]), .s_axis_tvalid(tvalid[2]),
    .s_axis_tready(tready[2]), .s_axis_tlast(tlast[2]), .baud_div(baud_div),
    .uart_tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]), .pkt_done(pkt[2]),
    .fifo_level(level[2]));

  axis_uart_tx_cfg #(.IDLE_GAP(2)) u_gap (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata[3]), .s_axis_tvalid(tvalid[3]),
    .s_axis_tready(tready[3]), .s_axis_tlast(tlast[3]), .baud_div(baud_div),
    .uart_tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]), .pkt_done(pkt[3]),
    .fifo_level(level[3]));

  // Expected line value of bit b of a frame: start, LSB-first data, parity, stops.
  function automatic logic exp_bit(input int k, input logic [7:0] d, input int b);
    int ones;
    ones = $countones(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR[k] != 0 && b == 9) return (PAR[k] == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
    return 1'b1;
  endfunction

  task automatic push(input int k, input logic [7:0] d, input logic l, output int acc_cyc);
    int t;
    t = 0;
    @(negedge clk);
    tdata[k]  = d;
    tlast[k]  = l;
    tvalid[k] = 1'b1;
    while (!tready[k] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tready[k] !== 1'b1) begin
      failures++;
      $display("FAIL push_timeout inst=%0d tready=%b expected 1", k, tready[k]);
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    tvalid[k] = 1'b0;
  endtask

  // Waits for the start bit, then checks every cycle of the frame (and gap).
  task automatic recv(input int k, input logic [7:0] d, input logic l, input int div,
                      output int start_cyc);
    int   nb, t;
    logic last_smp, eb, ep;
    nb = 1 + 8 + ((PAR[k] != 0) ? 1 : 0) + STP[k];
    t  = 0;
    start_cyc = -1;
    @(negedge clk);
    while (txl[k] !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (txl[k] !== 1'b0) begin
      failures++;
      $display("FAIL start_timeout inst=%0d uart_tx=%b expected 0", k, txl[k]);
      return;
    end
    start_cyc = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int s = 0; s <= div; s++) begin
        if (!(b == 0 && s == 0)) @(negedge clk);
        eb       = exp_bit(k, d, b);
        last_smp = (b == nb - 1) && (s == div);
        ep       = (GAPB[k] == 0) && l && last_smp;
        checks++;
        if (txl[k] !== eb) begin
          failures++;
          $display("FAIL line inst=%0d data=%h bit=%0d cyc=%0d got=%b exp=%b", k, d, b, s, txl[k], eb);
        end
        checks++;
        if (done[k] !== last_smp) begin
          failures++;
          $display("FAIL tx_done inst=%0d data=%h bit=%0d cyc=%0d got=%b exp=%b", k, d, b, s, done[k], last_smp);
        end
        checks++;
        if (pkt[k] !== ep) begin
          failures++;
          $display("FAIL pkt_done inst=%0d data=%h bit=%0d cyc=%0d got=%b exp=%b", k, d, b, s, pkt[k], ep);
        end
        if (!last_smp) begin
          checks++;
          if (busy[k] !== 1'b1) begin
            failures++;
            $display("FAIL tx_busy inst=%0d bit=%0d cyc=%0d got=%b exp=1", k, b, s, busy[k]);
          end
        end
      end
    end
    if (l && GAPB[k] > 0) begin
      for (int g = 0; g < GAPB[k] * (div + 1); g++) begin
        @(negedge clk);
        ep = (g == GAPB[k] * (div + 1) - 1);
        checks++;
        if (txl[k] !== 1'b1 || done[k] !== 1'b0 || pkt[k] !== ep) begin
          failures++;
          $display("FAIL gap inst=%0d cyc=%0d line=%b done=%b pkt=%b exp line=1 done=0 pkt=%b",
                   k, g, txl[k], done[k], pkt[k], ep);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (txl[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 || pkt[k] !== 1'b0 ||
          level[k] !== 4'd0 || tready[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state inst=%0d tx=%b busy=%b done=%b pkt=%b level=%0d tready=%b exp 1,0,0,0,0,0",
                 k, txl[k], busy[k], done[k], pkt[k], level[k], tready[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tready[k] !== 1'b1) begin
        failures++;
        $display("FAIL ready_after_reset inst=%0d got=%b exp=1", k, tready[k]);
      end
    end
  endtask

  task automatic test_8n1();
    int acc, st;
    logic [7:0] d;
    logic l;
    baud_div = 16'd3;
    fork
      push(0, 8'hA5, 1'b0, acc);
      recv(0, 8'hA5, 1'b0, 3, st);
    join
    checks++;
    if (st - acc !== 2) begin
      failures++;
      $display("FAIL latency got=%0d exp=2", st - acc);
    end
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      l = 1'($urandom);
      baud_div = 16'($urandom_range(1, 4));
      fork
        push(0, d, l, acc);
        recv(0, d, l, int'(baud_div), st);
      join
    end
  endtask

  task automatic test_parity();
    int acc, st, dv;
    logic [7:0] d;
    for (int k = 1; k <= 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        d  = (i == 0) ? 8'h07 : 8'($urandom);
        dv = (i == 0) ? 3 : int'($urandom_range(1, 4));
        baud_div = 16'(dv);
        fork
          push(k, d, 1'b0, acc);
          recv(k, d, 1'b0, dv, st);
        join
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, st;
    logic [7:0] q [12];
    baud_div = 16'd3;
    mon_en = 1'b1;
    fork
      for (int i = 0; i < 12; i++) push(0, 8'(i), 1'b0, acc);
      for (int i = 0; i < 12; i++) recv(0, 8'(i), 1'b0, 3, st);
    join
    checks++;
    if (max_level !== 8) begin
      failures++;
      $display("FAIL b2b_max_level got=%0d exp=8", max_level);
    end
    checks++;
    if (saw_full !== 1'b1) begin
      failures++;
      $display("FAIL b2b_tready_low got=%b exp=1", saw_full);
    end
    mon_en = 1'b0;
    for (int i = 0; i < 12; i++) q[i] = 8'($urandom);
    baud_div = 16'($urandom_range(1, 3));
    fork
      for (int i = 0; i < 12; i++) push(1, q[i], 1'b0, acc);
      for (int i = 0; i < 12; i++) recv(1, q[i], 1'b0, int'(baud_div), st);
    join
    @(negedge clk);
    checks++;
    if (level[1] !== 4'd0) begin
      failures++;
      $display("FAIL b2b_drain level got=%0d exp=0", level[1]);
    end
  endtask

  task automatic test_gap();
    int acc, st, nlast;
    logic [7:0] d [8];
    logic       l [8];
    d[0] = 8'h11; l[0] = 1'b0;
    d[1] = 8'h22; l[1] = 1'b1;
    d[2] = 8'h33; l[2] = 1'b0;
    nlast = 1;
    for (int i = 3; i < 8; i++) begin
      d[i] = 8'($urandom);
      l[i] = 1'($urandom);
      if (l[i]) nlast++;
    end
    baud_div = 16'd3;
    @(negedge clk);
    mon_en = 1'b1;
    fork
      for (int i = 0; i < 3; i++) push(3, d[i], l[i], acc);
      for (int i = 0; i < 3; i++) recv(3, d[i], l[i], 3, st);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (pkt_cnt3 !== 1) begin
      failures++;
      $display("FAIL gap_pkt_count got=%0d exp=1", pkt_cnt3);
    end
    fork
      for (int i = 3; i < 8; i++) push(3, d[i], l[i], acc);
      for (int i = 3; i < 8; i++) recv(3, d[i], l[i], 3, st);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (pkt_cnt3 !== nlast) begin
      failures++;
      $display("FAIL gap_pkt_count_rand got=%0d exp=%0d", pkt_cnt3, nlast);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_baud_change();
    int acc, st;
    logic [7:0] d1, d2;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    baud_div = 16'd3;
    fork
      begin
        push(0, d1, 1'b0, acc);
        push(0, d2, 1'b1, acc);
      end
      begin
        recv(0, d1, 1'b0, 3, st);
        recv(0, d2, 1'b1, 7, st);
      end
      begin
        repeat (12) @(negedge clk);
        baud_div = 16'd7;
      end
    join
    baud_div = 16'd3;
  endtask

  task automatic test_mid_reset();
    int acc, st, t;
    logic [7:0] d;
    baud_div = 16'd3;
    fork
      begin
        push(0, 8'($urandom), 1'b0, acc);
        push(0, 8'($urandom), 1'b0, acc);
      end
      begin
        t = 0;
        @(negedge clk);
        while (txl[0] !== 1'b0 && t < 200) begin
          @(negedge clk);
          t++;
        end
        repeat (17) @(negedge clk);
      end
    join
    checks++;
    if (level[0] !== 4'd1 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset level=%0d busy=%b exp level=1 busy=1", level[0], busy[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (txl[0] !== 1'b1 || busy[0] !== 1'b0 || level[0] !== 4'd0 || tready[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset tx=%b busy=%b level=%0d tready=%b exp 1,0,0,0",
               txl[0], busy[0], level[0], tready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    d = 8'($urandom);
    fork
      push(0, d, 1'b1, acc);
      recv(0, d, 1'b1, 3, st);
    join
    repeat (10) @(negedge clk);
    checks++;
    if (txl[0] !== 1'b1 || busy[0] !== 1'b0 || level[0] !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_idle tx=%b busy=%b level=%0d exp 1,0,0", txl[0], busy[0], level[0]);
    end
  endtask

  initial begin
    rst      = 1'b1;
    baud_div = 16'd3;
    for (int k = 0; k < 4; k++) begin
      tdata[k]  = '0;
      tvalid[k] = 1'b0;
      tlast[k]  = 1'b0;
    end
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_gap();
    test_baud_change();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
